firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench

- IJTAG TDR-based controller that owns a W-bit test data mux; drives its `ijtag_select` and `ijtag_data_in` inputs.
- Shifts a request word (enable + data) from the scan chain and captures the functional value for observation.
- On update, sequences the mux make/break so that the select only changes when the data is already stable.
- Sits in the gate1 IJTAG network, one instance per data mux.

---
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 155 +++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR controller for one gate1 test data mux: shift/capture request word, make/break sequenced update.
// Optional even-parity check on the request word: define FIREBIRD7_IN_MUX_CTRL_PARITY_EN.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int W = 19
) (
  input  logic         ijtag_tck,
  input  logic         ijtag_reset,
  input  logic         ijtag_sel,
  input  logic         ijtag_ce,
  input  logic         ijtag_se,
  input  logic         ijtag_ue,
  input  logic         ijtag_si,
  output logic         ijtag_so,
  input  logic [W-1:0] functional_data_in,
  output logic         mux_select,
  output logic [W-1:0] mux_data,
  output logic         switch_busy
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  ,
  output logic         parity_error
`endif
);

`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  localparam int SRW = W + 2;
`else
  localparam int SRW = W + 1;
`endif

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_DISARM = 2'd3;

  logic [SRW-1:0] sr;
  logic [1:0]     state;
  logic           capture, shift, update, upd_ok, ev_valid;
  logic           pend_valid, pend_en;
  logic [W-1:0]   pend_data, hold_data;
  logic           act_valid, act_en;
  logic [W-1:0]   act_data;

  assign capture  = ijtag_sel & ijtag_ce;
  assign shift    = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign update   = ijtag_sel & ijtag_ue;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  assign upd_ok   = ~(^sr);
`else
  assign upd_ok   = 1'b1;
`endif
  assign ev_valid = update & upd_ok;
  assign ijtag_so = sr[0];

  // In a stable state a live event supersedes anything parked during the transition.
  always_comb begin
    act_valid = ev_valid | pend_valid;
    act_en    = pend_en;
    act_data  = pend_data;
    if (ev_valid) begin
      act_en   = sr[W];
      act_data = sr[W-1:0];
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr <= '0;
    end else if (capture) begin
      sr[W-1:0] <= functional_data_in;
      sr[W]     <= mux_select;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
      sr[W+1]   <= parity_error;
`endif
    end else if (shift) begin
      sr <= {ijtag_si, sr[SRW-1:1]};
    end
  end

`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      parity_error <= 1'b0;
    end else if (update && !upd_ok) begin
      parity_error <= 1'b1;
    end
  end
`endif

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state       <= ST_OFF;
      mux_select  <= 1'b0;
      mux_data    <= '0;
      switch_busy <= 1'b0;
      pend_valid  <= 1'b0;
      pend_en     <= 1'b0;
      pend_data   <= '0;
      hold_data   <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          pend_valid <= 1'b0;
          if (act_valid) begin
            mux_data <= act_data;
            if (act_en) begin
              state       <= ST_ARM;
              switch_busy <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          state       <= ST_ON;
          mux_select  <= 1'b1;
          switch_busy <= 1'b0;
          if (ev_valid) begin
            pend_valid <= 1'b1;
            pend_en    <= sr[W];
            pend_data  <= sr[W-1:0];
          end
        end
        ST_ON: begin
          pend_valid <= 1'b0;
          if (act_valid) begin
            if (act_en) begin
              mux_data <= act_data;
            end else begin
              // Break first: data is only applied once the select has dropped.
              mux_select  <= 1'b0;
              hold_data   <= act_data;
              state       <= ST_DISARM;
              switch_busy <= 1'b1;
            end
          end
        end
        ST_DISARM: begin
          state       <= ST_OFF;
          mux_data    <= hold_data;
          switch_busy <= 1'b0;
          if (ev_valid) begin
            pend_valid <= 1'b1;
            pend_en    <= sr[W];
            pend_data  <= sr[W-1:0];
          end
        end
        default: begin
          state       <= ST_OFF;
          mux_select  <= 1'b0;
          switch_busy <= 1'b0;
          pend_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Self-checking bench for firebird7_in_gate1_tessent_data_mux_ctrl: directed make/break cases plus random TDR traffic.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;
  localparam int W = 19;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  localparam int SRW = W + 2;
`else
  localparam int SRW = W + 1;
`endif

  logic         ijtag_tck = 1'b0;
  logic         ijtag_reset = 1'b0;
  logic         ijtag_sel = 1'b0, ijtag_ce = 1'b0, ijtag_se = 1'b0, ijtag_ue = 1'b0, ijtag_si = 1'b0;
  logic         ijtag_so;
  logic [W-1:0] functional_data_in = '0;
  logic         mux_select;
  logic [W-1:0] mux_data;
  logic         switch_busy;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
  logic         parity_error;
`endif

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_data_mux_ctrl #(.W(W)) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .mux_select         (mux_select),
    .mux_data           (mux_data),
    .switch_busy        (switch_busy)
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    ,
    .parity_error       (parity_error)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: select level, "in transition" flag with its direction, parked request.
  logic [SRW-1:0] m_sr;
  logic           m_sel, m_busy, m_make, m_perr;
  logic [W-1:0]   m_data, m_hold;
  logic [W:0]     m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit sel, input bit ce, input bit se,
                            input bit ue, input bit si, input logic [W-1:0] fdi);
    bit             ev, en, have, perr_set;
    logic [W-1:0]   d;
    logic [W:0]     e;
    logic [SRW-1:0] c;
    if (rst) begin
      m_sr = '0; m_sel = 0; m_busy = 0; m_make = 0; m_perr = 0;
      m_data = '0; m_hold = '0; m_q.delete();
      return;
    end
    perr_set = 0;
    en = m_sr[W];
    d  = m_sr[W-1:0];
    ev = sel && ue;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    if (ev && (^m_sr)) begin
      ev = 0;
      perr_set = 1;
    end
`endif
    if (sel && ce) begin
      c = '0;
      c[W-1:0] = fdi;
      c[W] = m_sel;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
      c[W+1] = m_perr;
`endif
      m_sr = c;
    end else if (sel && se) begin
      m_sr = {si, m_sr[SRW-1:1]};
    end
    if (m_busy) begin
      if (ev) begin
        m_q.delete();
        m_q.push_back({en, d});
      end
      if (m_make) m_sel = 1;
      else m_data = m_hold;
      m_busy = 0;
    end else begin
      have = 0;
      e = '0;
      if (ev) begin have = 1; e = {en, d}; end
      else if (m_q.size() > 0) begin have = 1; e = m_q[0]; end
      m_q.delete();
      if (have) begin
        if (!m_sel) begin
          m_data = e[W-1:0];
          if (e[W]) begin m_busy = 1; m_make = 1; end
        end else if (e[W]) begin
          m_data = e[W-1:0];
        end else begin
          m_sel = 0; m_hold = e[W-1:0]; m_busy = 1; m_make = 0;
        end
      end
    end
    if (perr_set) m_perr = 1;
  endtask

  // Called at negedge; drives, waits for the edge, advances the model and compares.
  task automatic tick(input bit rst, input bit sel, input bit ce, input bit se,
                      input bit ue, input bit si, input logic [W-1:0] fdi);
    ijtag_reset = rst; ijtag_sel = sel; ijtag_ce = ce; ijtag_se = se;
    ijtag_ue = ue; ijtag_si = si; functional_data_in = fdi;
    @(posedge ijtag_tck);
    model_edge(rst, sel, ce, se, ue, si, fdi);
    #1;
    check("so", 64'(ijtag_so), 64'(m_sr[0]));
    check("mux_select", 64'(mux_select), 64'(m_sel));
    check("mux_data", 64'(mux_data), 64'(m_data));
    check("switch_busy", 64'(switch_busy), 64'(m_busy));
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    check("parity_error", 64'(parity_error), 64'(m_perr));
`endif
    @(negedge ijtag_tck);
  endtask

  task automatic shift_word(input bit en, input logic [W-1:0] d, input bit bad_par);
    logic [SRW-1:0] w;
    w = '0;
    w[W-1:0] = d;
    w[W] = en;
`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    w[W+1] = (^{en, d}) ^ bad_par;
`else
    if (bad_par) w = ~w;
`endif
    for (int i = 0; i < SRW; i++) tick(0, 1, 0, 1, 0, w[i], '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0, '0);
  endtask

  logic [19:0] so_word;

  initial begin
    @(negedge ijtag_tck);
    // Reset and capture/shift-out of the functional value
    tick(1, 0, 0, 0, 0, 0, '0);
    tick(1, 0, 0, 0, 0, 0, '0);
    check("rst_sel", 64'(mux_select), 64'(0));
    check("rst_data", 64'(mux_data), 64'(0));
    tick(0, 1, 1, 1, 0, 0, 19'h5A5A5);
    so_word[0] = ijtag_so;
    for (int i = 1; i < 20; i++) begin
      tick(0, 1, 0, 1, 0, 0, '0);
      so_word[i] = ijtag_so;
    end
    check("capture_so_seq", 64'(so_word), 64'({1'b0, 19'h5A5A5}));

    // Make
    shift_word(1, 19'h7FFFF, 0);
    tick(0, 1, 0, 0, 1, 0, '0);
    check("make_data", 64'(mux_data), 64'(19'h7FFFF));
    check("make_busy", 64'(switch_busy), 64'(1));
    check("make_sel_low", 64'(mux_select), 64'(0));
    idle(1);
    check("make_sel", 64'(mux_select), 64'(1));
    check("make_busy_done", 64'(switch_busy), 64'(0));

    // Data change while ON, then break
    shift_word(1, 19'h00123, 0);
    tick(0, 1, 0, 0, 1, 0, '0);
    check("on_data", 64'(mux_data), 64'(19'h00123));
    check("on_sel", 64'(mux_select), 64'(1));
    shift_word(0, 19'h00000, 0);
    tick(0, 1, 0, 0, 1, 0, '0);
    check("break_sel", 64'(mux_select), 64'(0));
    check("break_data_held", 64'(mux_data), 64'(19'h00123));
    idle(1);
    check("break_data", 64'(mux_data), 64'(0));
    idle(2);

    // ue held two cycles with a shift in between: second event parks during ARM
    shift_word(1, 19'h11111, 0);
    tick(0, 1, 0, 1, 1, 0, '0);
    tick(0, 1, 0, 0, 1, 0, '0);
    idle(4);
`ifndef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    check("pend_data", 64'(mux_data), 64'(19'h48888));
    check("pend_sel", 64'(mux_select), 64'(0));
`endif

    // Reset while in ARM drops the parked event
    shift_word(1, 19'h3C3C3, 0);
    tick(0, 1, 0, 0, 1, 0, '0);
    tick(1, 1, 0, 0, 1, 0, '0);
    check("rst_arm_sel", 64'(mux_select), 64'(0));
    check("rst_arm_data", 64'(mux_data), 64'(0));
    check("rst_arm_busy", 64'(switch_busy), 64'(0));
    idle(3);
    check("rst_arm_quiet", 64'({mux_select, mux_data}), 64'(0));

`ifdef FIREBIRD7_IN_MUX_CTRL_PARITY_EN
    shift_word(1, 19'h0F0F0, 1);
    tick(0, 1, 0, 0, 1, 0, '0);
    check("par_err", 64'(parity_error), 64'(1));
    check("par_ignored", 64'(mux_data), 64'(0));
    tick(0, 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < SRW - 1; i++) tick(0, 1, 0, 1, 0, 0, '0);
    check("par_so_msb", 64'(ijtag_so), 64'(1));
    shift_word(0, 19'h00055, 0);
    tick(0, 1, 0, 0, 1, 0, '0);
    check("par_ok_data", 64'(mux_data), 64'(19'h00055));
    check("par_sticky", 64'(parity_error), 64'(1));
`endif

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
